// File: rtl/dac_display_scanner_if.sv
// Bundle between the DAC register bank side and the display scanner.
// The master drives channel data and controls; the slave (the scanner)
// returns the formatted display words and status.
interface dac_display_scanner_if #(
  parameter int NUM_CH = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH*16-1:0] dac_flat;
  logic [NUM_CH*16-1:0] inp_flat;
  logic [CH_W-1:0]      ch_select;
  logic                 auto_scan;
  logic [1:0]           mode;
  logic                 freeze;
  logic [31:0]          display;
  logic [7:0]           digit_enable;
  logic [CH_W-1:0]      cur_channel;
  logic                 update_strobe;

  modport master (
    output dac_flat, inp_flat, ch_select, auto_scan, mode, freeze,
    input  display, digit_enable, cur_channel, update_strobe
  );

  modport slave (
    input  dac_flat, inp_flat, ch_select, auto_scan, mode, freeze,
    output display, digit_enable, cur_channel, update_strobe
  );
endinterface

// File: rtl/dac_display_scanner.sv
// Channel selector / auto-scanner that formats the DAC input and output words
// of the selected channel for an 8-digit hex seven-segment driver.
// Pipeline: ch_select -> cur_channel_q -> display_q (two cycles);
// channel data -> display_q (one cycle).
module dac_display_scanner #(
  parameter int NUM_CH       = 8,
  parameter int DATA_W       = 16,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input logic                  clk,
  input logic                  resetn,
  dac_display_scanner_if.slave bus
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int DW_W = $clog2(DWELL_CYCLES);

  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [15:0]     DATA_MASK  = 16'((33'd1 << DATA_W) - 33'd1);

  logic [CH_W-1:0] cur_channel_q, cur_channel_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [31:0]     display_q, display_d;
  logic [7:0]      digit_enable_q, digit_enable_d;
  logic            update_strobe_q, update_strobe_d;

  logic [15:0]     dac_word [NUM_CH];
  logic [15:0]     inp_word [NUM_CH];
  logic [CH_W-1:0] ch_clamped;
  logic [15:0]     sel_dac;
  logic [15:0]     sel_inp;
  logic [31:0]     fmt_display;
  logic [7:0]      fmt_enable;

  // Unpack the flat buses into per-channel words, dropping bits above DATA_W.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign dac_word[gi] = bus.dac_flat[gi*16 +: 16] & DATA_MASK;
    assign inp_word[gi] = bus.inp_flat[gi*16 +: 16] & DATA_MASK;
  end

  // Out-of-range manual selections pin to the last real channel.
  assign ch_clamped = (32'(bus.ch_select) >= NUM_CH) ? CH_LAST : bus.ch_select;

  // Channel pointer and dwell counter; dwell stays at 0 in manual mode so a
  // return to auto-scan always starts a full dwell on the current channel.
  always_comb begin
    cur_channel_d = cur_channel_q;
    dwell_d       = dwell_q;
    if (bus.auto_scan) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d       = '0;
        cur_channel_d = (cur_channel_q == CH_LAST) ? '0 : cur_channel_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end else begin
      dwell_d       = '0;
      cur_channel_d = ch_clamped;
    end
  end

  // Pick the words of the registered channel (not the raw select).
  always_comb begin
    sel_dac = '0;
    sel_inp = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_channel_q == CH_W'(k)) begin
        sel_dac = dac_word[k];
        sel_inp = inp_word[k];
      end
    end
  end

  // Build the display word and digit mask for the requested mode.
  always_comb begin
    fmt_display = {sel_inp, sel_dac};
    fmt_enable  = 8'hFF;
    case (bus.mode)
      2'd0: begin
        fmt_display = {sel_inp, sel_dac};
        fmt_enable  = 8'hFF;
      end
      2'd1: begin
        fmt_display = {16'h0, sel_dac};
        fmt_enable  = 8'h0F;
      end
      2'd2: begin
        fmt_display = {4'(cur_channel_q), 12'h0, sel_dac};
        fmt_enable  = 8'h8F;
      end
      default: begin
        fmt_display = {sel_inp, 16'h0};
        fmt_enable  = 8'hF0;
      end
    endcase
  end

  // Display register: load while not frozen, strobe only when the load
  // actually changes what is shown.
  always_comb begin
    display_d       = display_q;
    digit_enable_d  = digit_enable_q;
    update_strobe_d = 1'b0;
    if (!bus.freeze) begin
      display_d       = fmt_display;
      digit_enable_d  = fmt_enable;
      update_strobe_d = (fmt_display != display_q) || (fmt_enable != digit_enable_q);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_channel_q   <= '0;
      dwell_q         <= '0;
      display_q       <= 32'h0;
      digit_enable_q  <= 8'h00;
      update_strobe_q <= 1'b0;
    end else begin
      cur_channel_q   <= cur_channel_d;
      dwell_q         <= dwell_d;
      display_q       <= display_d;
      digit_enable_q  <= digit_enable_d;
      update_strobe_q <= update_strobe_d;
    end
  end

  assign bus.display       = display_q;
  assign bus.digit_enable  = digit_enable_q;
  assign bus.cur_channel   = cur_channel_q;
  assign bus.update_strobe = update_strobe_q;

endmodule
